// File: rtl/hs32_reg_arb.sv
// Arbiter sharing a single-write / dual-read register file between requester A
// (execute pipeline) and requester B (debug / context-save engine).
module hs32_reg_arb #(
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 32,
  parameter bit          PRIO_A   = 1'b0,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_wadr_i,
  input  logic [DW-1:0] a_din_i,
  input  logic [AW-1:0] a_radr1_i,
  input  logic [AW-1:0] a_radr2_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata1_o,
  output logic [DW-1:0] a_rdata2_o,
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_wadr_i,
  input  logic [DW-1:0] b_din_i,
  input  logic [AW-1:0] b_radr1_i,
  input  logic [AW-1:0] b_radr2_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata1_o,
  output logic [DW-1:0] b_rdata2_o,
  input  logic          b_lock_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_wadr_o,
  output logic [DW-1:0] rf_din_o,
  output logic [AW-1:0] rf_radr1_o,
  output logic [AW-1:0] rf_radr2_o,
  input  logic [DW-1:0] rf_dout1_i,
  input  logic [DW-1:0] rf_dout2_i
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

  typedef enum logic {ST_ARB, ST_LOCK} state_e;
  typedef enum logic {REQ_A, REQ_B} req_e;

  state_e        state_q, state_d;
  req_e          rr_last_q, rr_last_d;
  logic [WW-1:0] a_wait_q, a_wait_d, b_wait_q, b_wait_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          a_gnt, b_gnt;

  logic [AW-1:0] rf_wadr_q, rf_radr1_q, rf_radr2_q;
  logic [DW-1:0] rf_din_q;

  logic          a_pend_q, b_pend_q;
  logic [DW-1:0] a_rdata1_q, a_rdata2_q, b_rdata1_q, b_rdata2_q;

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (a_req_i && b_req_i) begin
          if (a_wait_q == WAIT_MAX)                      a_gnt = 1'b1;
          else if (b_wait_q == WAIT_MAX)                 b_gnt = 1'b1;
          else if (PRIO_A || rr_last_q == REQ_B)         a_gnt = 1'b1;
          else                                           b_gnt = 1'b1;
        end else begin
          a_gnt = a_req_i;
          b_gnt = b_req_i;
        end
        // The entering grant is the first of the locked run.
        if (b_gnt && b_lock_i && MAX_LOCK > 1) begin
          state_d    = ST_LOCK;
          lock_cnt_d = LW'(1);
        end
      end
      ST_LOCK: begin
        b_gnt = b_req_i;
        if (!b_req_i || !b_lock_i || lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (!rst_ni) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
    if (a_gnt)      rr_last_d = REQ_A;
    else if (b_gnt) rr_last_d = REQ_B;
  end

  always_comb begin
    a_wait_d = a_wait_q;
    if (!a_req_i || a_gnt)                             a_wait_d = '0;
    else if (state_q == ST_ARB && a_wait_q != WAIT_MAX) a_wait_d = a_wait_q + 1'b1;
    b_wait_d = b_wait_q;
    if (!b_req_i || b_gnt)          b_wait_d = '0;
    else if (b_wait_q != WAIT_MAX)  b_wait_d = b_wait_q + 1'b1;
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_wadr_o  = rf_wadr_q;
    rf_din_o   = rf_din_q;
    rf_radr1_o = rf_radr1_q;
    rf_radr2_o = rf_radr2_q;
    if (a_gnt) begin
      rf_we_o    = a_we_i;
      rf_wadr_o  = a_wadr_i;
      rf_din_o   = a_din_i;
      rf_radr1_o = a_radr1_i;
      rf_radr2_o = a_radr2_i;
    end else if (b_gnt) begin
      rf_we_o    = b_we_i;
      rf_wadr_o  = b_wadr_i;
      rf_din_o   = b_din_i;
      rf_radr1_o = b_radr1_i;
      rf_radr2_o = b_radr2_i;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ARB;
      rr_last_q  <= REQ_B;
      a_wait_q   <= '0;
      b_wait_q   <= '0;
      lock_cnt_q <= '0;
      rf_wadr_q  <= '0;
      rf_din_q   <= '0;
      rf_radr1_q <= '0;
      rf_radr2_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      a_wait_q   <= a_wait_d;
      b_wait_q   <= b_wait_d;
      lock_cnt_q <= lock_cnt_d;
      rf_wadr_q  <= rf_wadr_o;
      rf_din_q   <= rf_din_o;
      rf_radr1_q <= rf_radr1_o;
      rf_radr2_q <= rf_radr2_o;
    end
  end

  // NOTE: data holding registers are reset too, since read data must read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_rdata1_q <= '0;
      a_rdata2_q <= '0;
      b_rdata1_q <= '0;
      b_rdata2_q <= '0;
    end else begin
      a_pend_q <= a_gnt && !a_we_i;
      b_pend_q <= b_gnt && !b_we_i;
      if (a_pend_q) begin
        a_rdata1_q <= rf_dout1_i;
        a_rdata2_q <= rf_dout2_i;
      end
      if (b_pend_q) begin
        b_rdata1_q <= rf_dout1_i;
        b_rdata2_q <= rf_dout2_i;
      end
    end
  end

  // The RF registers its read data, so the response is passed through in the cycle after issue.
  assign a_gnt_o    = a_gnt;
  assign b_gnt_o    = b_gnt;
  assign a_rvalid_o = a_pend_q;
  assign b_rvalid_o = b_pend_q;
  assign a_rdata1_o = a_pend_q ? rf_dout1_i : a_rdata1_q;
  assign a_rdata2_o = a_pend_q ? rf_dout2_i : a_rdata2_q;
  assign b_rdata1_o = b_pend_q ? rf_dout1_i : b_rdata1_q;
  assign b_rdata2_o = b_pend_q ? rf_dout2_i : b_rdata2_q;

endmodule

// File: tb/tb_hs32_reg_arb.sv
// Self-checking bench for hs32_reg_arb: RF model, read-data scoreboard and
// directed arbitration sequences (round-robin, RAW, reset drop, lock, starvation).
module tb_hs32_reg_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [3:0]  a_wadr, a_radr1, a_radr2, b_wadr, b_radr1, b_radr2;
  logic [31:0] a_din, b_din;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic        rf_we;
  logic [3:0]  rf_wadr, rf_radr1, rf_radr2;
  logic [31:0] rf_din, rf_dout1, rf_dout2;

  logic        p_a_req, p_b_req;
  logic        p_a_gnt, p_a_rvalid, p_b_gnt, p_b_rvalid, p_rf_we;
  logic [31:0] p_a_rdata1, p_a_rdata2, p_b_rdata1, p_b_rdata2, p_rf_din;
  logic [3:0]  p_rf_wadr, p_rf_radr1, p_rf_radr2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] d1;
    logic [31:0] d2;
  } rsp_t;
  rsp_t        qa[$];
  rsp_t        qb[$];
  logic [31:0] shadow [16];
  logic [31:0] rf_mem [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hs32_reg_arb #(.AW(4), .DW(32), .PRIO_A(1'b0), .MAX_WAIT(8), .MAX_LOCK(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_wadr_i(a_wadr), .a_din_i(a_din),
    .a_radr1_i(a_radr1), .a_radr2_i(a_radr2), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
    .a_rdata1_o(a_rdata1), .a_rdata2_o(a_rdata2),
    .b_req_i(b_req), .b_we_i(b_we), .b_wadr_i(b_wadr), .b_din_i(b_din),
    .b_radr1_i(b_radr1), .b_radr2_i(b_radr2), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
    .b_rdata1_o(b_rdata1), .b_rdata2_o(b_rdata2), .b_lock_i(b_lock),
    .rf_we_o(rf_we), .rf_wadr_o(rf_wadr), .rf_din_o(rf_din),
    .rf_radr1_o(rf_radr1), .rf_radr2_o(rf_radr2),
    .rf_dout1_i(rf_dout1), .rf_dout2_i(rf_dout2)
  );

  // Fixed-priority instance; only its grants are observed.
  hs32_reg_arb #(.AW(4), .DW(32), .PRIO_A(1'b1), .MAX_WAIT(8), .MAX_LOCK(16)) dut_p (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(p_a_req), .a_we_i(a_we), .a_wadr_i(a_wadr), .a_din_i(a_din),
    .a_radr1_i(a_radr1), .a_radr2_i(a_radr2), .a_gnt_o(p_a_gnt), .a_rvalid_o(p_a_rvalid),
    .a_rdata1_o(p_a_rdata1), .a_rdata2_o(p_a_rdata2),
    .b_req_i(p_b_req), .b_we_i(b_we), .b_wadr_i(b_wadr), .b_din_i(b_din),
    .b_radr1_i(b_radr1), .b_radr2_i(b_radr2), .b_gnt_o(p_b_gnt), .b_rvalid_o(p_b_rvalid),
    .b_rdata1_o(p_b_rdata1), .b_rdata2_o(p_b_rdata2), .b_lock_i(b_lock),
    .rf_we_o(p_rf_we), .rf_wadr_o(p_rf_wadr), .rf_din_o(p_rf_din),
    .rf_radr1_o(p_rf_radr1), .rf_radr2_o(p_rf_radr2),
    .rf_dout1_i(32'h0), .rf_dout2_i(32'h0)
  );

  // Register file model: registered read outputs, updated only when not writing.
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_wadr] <= rf_din;
    else begin
      rf_dout1 <= rf_mem[rf_radr1];
      rf_dout2 <= rf_mem[rf_radr2];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [3:0] wadr,
                       input logic [31:0] din, input logic [3:0] r1, input logic [3:0] r2);
    a_req = req; a_we = we; a_wadr = wadr; a_din = din; a_radr1 = r1; a_radr2 = r2;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [3:0] wadr,
                       input logic [31:0] din, input logic [3:0] r1, input logic [3:0] r2);
    b_req = req; b_we = we; b_wadr = wadr; b_din = din; b_radr1 = r1; b_radr2 = r2;
  endtask

  // Scoreboard: expected read data pushed at issue, compared on the due cycle.
  always @(negedge clk) begin
    rsp_t e;
    #2;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      check("gnt_exclusive", a_gnt & b_gnt, 1'b0);
      check("rf_we_mux", rf_we, (a_gnt & a_we) | (b_gnt & b_we));
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        check("a_rvalid", a_rvalid, 1'b1);
        check("a_rdata1", a_rdata1, e.d1);
        check("a_rdata2", a_rdata2, e.d2);
      end else if (a_rvalid) check("a_rvalid_unexpected", a_rvalid, 1'b0);
      if (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        check("b_rvalid", b_rvalid, 1'b1);
        check("b_rdata1", b_rdata1, e.d1);
        check("b_rdata2", b_rdata2, e.d2);
      end else if (b_rvalid) check("b_rvalid_unexpected", b_rvalid, 1'b0);
      if (a_gnt && !a_we) qa.push_back('{cyc + 1, shadow[a_radr1], shadow[a_radr2]});
      if (b_gnt && !b_we) qb.push_back('{cyc + 1, shadow[b_radr1], shadow[b_radr2]});
      if (a_gnt && a_we) shadow[a_wadr] = a_din;
      if (b_gnt && b_we) shadow[b_wadr] = b_din;
    end
  end

  initial begin
    int idx;
    int lg[$];
    int first_b, second_b;

    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    rf_dout1 = '0; rf_dout2 = '0;
    rst_n = 1'b0; b_lock = 1'b0; p_a_req = 1'b0; p_b_req = 1'b0;
    set_a(1, 0, 0, 0, 1, 2);
    set_b(1, 1, 5, 32'h1234_5678, 0, 0);

    // Reset state with both requesting
    repeat (2) @(negedge clk);
    #3;
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_b_gnt", b_gnt, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_a_rdata1", a_rdata1, 32'h0);
    check("rst_b_rdata2", b_rdata2, 32'h0);
    @(negedge clk);
    set_a(0, 0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // RAW: write R3 then read R3,R0 next cycle
    @(negedge clk);
    set_a(1, 1, 3, 32'hDEAD_BEEF, 0, 0);
    #3;
    check("raw_wr_gnt", a_gnt, 1'b1);
    check("raw_rf_we", rf_we, 1'b1);
    check("raw_rf_wadr", rf_wadr, 4'd3);
    check("raw_rf_din", rf_din, 32'hDEAD_BEEF);
    @(negedge clk);
    set_a(1, 0, 0, 0, 3, 0);
    #3;
    check("raw_rd_gnt", a_gnt, 1'b1);
    check("raw_rvalid_early", a_rvalid, 1'b0);
    @(negedge clk);
    set_a(0, 0, 0, 0, 0, 0);
    #3;
    check("raw_rvalid", a_rvalid, 1'b1);
    check("raw_rdata1", a_rdata1, 32'hDEAD_BEEF);
    check("raw_rdata2", a_rdata2, 32'h1000_0000);
    @(negedge clk);
    #3;
    check("raw_hold_rvalid", a_rvalid, 1'b0);
    check("raw_hold_rdata1", a_rdata1, 32'hDEAD_BEEF);

    // Read in flight dropped by reset
    @(negedge clk);
    set_a(1, 0, 0, 0, 5, 6);
    #3;
    check("drop_rd_gnt", a_gnt, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("drop_rvalid", a_rvalid, 1'b0);
    check("drop_rdata1", a_rdata1, 32'h0);
    check("drop_gnt_forced", a_gnt, 1'b0);
    @(negedge clk);
    #3;
    check("drop_gnt_forced2", a_gnt, 1'b0);
    check("drop_rvalid2", a_rvalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin from reset: A,B,A,B,... with fields held until each grant
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      set_a(1, 0, 0, 0, 4'((i + 1) / 2), 4'((i + 1) / 2 + 8));
      set_b(1, 0, 0, 0, 4'(15 - i / 2), 4'(i / 2 + 1));
      #3;
      check($sformatf("rr_a_gnt%0d", i), a_gnt, 1'(i % 2 == 0));
      check($sformatf("rr_b_gnt%0d", i), b_gnt, 1'(i % 2 == 1));
    end

    // Idle: no write, read addresses hold the last issue (A: R3,R11)
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_a(0, 0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0, 0);
      #3;
      check($sformatf("idle_rf_we%0d", i), rf_we, 1'b0);
      check($sformatf("idle_radr1_%0d", i), rf_radr1, 4'd3);
      check($sformatf("idle_radr2_%0d", i), rf_radr2, 4'd11);
    end

    // B write vs A read with rr_last=A: B issues, A the cycle after
    @(negedge clk);
    set_a(1, 0, 0, 0, 7, 3);
    set_b(1, 1, 9, 32'hCAFE_0009, 0, 0);
    #3;
    check("mix_b_gnt", b_gnt, 1'b1);
    check("mix_a_gnt", a_gnt, 1'b0);
    check("mix_rf_wadr", rf_wadr, 4'd9);
    @(negedge clk);
    set_b(0, 0, 0, 0, 0, 0);
    #3;
    check("mix_a_late_gnt", a_gnt, 1'b1);

    // Lock: 20 locked B writes while A keeps requesting
    idx = 0;
    for (int c = 0; c < 60 && idx < 20; c++) begin
      @(negedge clk);
      set_a(1, 0, 0, 0, 9, 1);
      b_lock = 1'b1;
      set_b(1, 1, 4'(idx), 32'hB000_0000 + 32'(idx), 0, 0);
      #3;
      lg.push_back(a_gnt ? 1 : (b_gnt ? 2 : 0));
      if (b_gnt) idx++;
    end
    check("lock_all_written", idx, 20);
    check("lock_log_len", lg.size(), 21);
    for (int i = 0; i < 21; i++)
      check($sformatf("lock_seq%0d", i), (lg.size() > i) ? lg[i] : -1, (i == 16) ? 1 : 2);
    @(negedge clk);
    set_a(0, 0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0, 0);
    b_lock = 1'b0;

    // Fixed priority starvation guard on dut_p
    @(negedge clk);
    set_b(0, 1, 2, 32'h5555_0002, 0, 0);
    p_a_req = 1'b1; p_b_req = 1'b1;
    first_b = -1; second_b = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      check($sformatf("prio_onehot%0d", c), p_a_gnt ^ p_b_gnt, 1'b1);
      if (p_b_gnt) begin
        if (first_b < 0) first_b = c;
        else if (second_b < 0) second_b = c;
      end
    end
    check("prio_first_b", first_b, 8);
    check("prio_second_b", second_b, 17);
    @(negedge clk);
    p_a_req = 1'b0; p_b_req = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    check("sb_a_empty", qa.size(), 0);
    check("sb_b_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
